// File: rtl/rho_serial.sv
// rho_serial: Keccak rho step (optionally fused with pi) over a 5x5 lane state, LPC lanes per cycle.
// Latency: 25/LPC cycles from accept to out_valid; the result is held in a register until accepted.
// Backpressure: in_ready is low unless IDLE; DONE holds out_data/out_valid until out_ready.
//
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data (25*W state in);
//        out_valid/out_ready/out_data (25*W state out); busy (high while lanes are being rotated).
// Parameters: W (lane width 8/16/32/64), LPC (lanes per cycle 1/5/25).
// Macro RHO_PI_FUSE_EN: when defined, rotated lane (x,y) lands at output lane (y, (2x+3y) mod 5).
// Lane (x,y) lives at bits [(5x+y)*W +: W] on both in_data and out_data.

module rho_serial #(
  parameter int W   = 64,
  parameter int LPC = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [25*W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [25*W-1:0] out_data,
  output logic            busy
);

  localparam int N  = 25 / LPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (!(W == 8 || W == 16 || W == 32 || W == 64)) begin : g_bad_w
      $error("rho_serial: W must be 8, 16, 32 or 64");
    end
    if (!(LPC == 1 || LPC == 5 || LPC == 25)) begin : g_bad_lpc
      $error("rho_serial: LPC must be 1, 5 or 25");
    end
  endgenerate

  // Raw Keccak rho offsets, indexed by lane number 5x+y.
  localparam int RHO [25] = '{
      0,  36,   3, 105, 210,
      1, 300,  10,  45,  66,
    190,   6, 171,  15, 253,
     28,  55, 153,  21, 120,
     91, 276, 231, 136,  78
  };

  // Output lane index for rotated source lane l.
  function automatic int lane_dst(input int l);
`ifdef RHO_PI_FUSE_EN
    return 5 * (l % 5) + (2 * (l / 5) + 3 * (l % 5)) % 5;
`else
    return l;
`endif
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [25*W-1:0] in_buf;

  // Every lane has a fixed rotation, so the rotations are pure wiring off the
  // buffer; the group counter only selects which lanes get written each cycle.
  logic [W-1:0] rot_lane [25];

  for (genvar l = 0; l < 25; l++) begin : g_rot
    localparam int S = RHO[l] % W;
    logic [W-1:0] lane;
    assign lane = in_buf[l*W +: W];
    if (S == 0) begin : g_id
      assign rot_lane[l] = lane;
    end else begin : g_rotl
      assign rot_lane[l] = {lane[W-1-S:0], lane[W-1:W-S]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      in_buf    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_buf   <= in_data;
            cnt      <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          for (int l = 0; l < 25; l++) begin
            if (cnt == CW'(l / LPC)) begin
              out_data[lane_dst(l)*W +: W] <= rot_lane[l];
            end
          end
          if (cnt == CW'(N - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rho_serial.sv
// tb_rho_serial: checks rho_serial at (W=64,LPC=5), (W=64,LPC=25) and (W=8,LPC=1).
// Expected states come from a bit-level rho (and pi when RHO_PI_FUSE_EN) model or hand tables.
// Results are queued at send time and popped when out_valid is seen.

module tb_rho_serial;

`ifdef RHO_PI_FUSE_EN
  localparam bit FUSE = 1'b1;
`else
  localparam bit FUSE = 1'b0;
`endif

  localparam int RHO_TAB [25] = '{
      0,  36,   3, 105, 210,
      1, 300,  10,  45,  66,
    190,   6, 171,  15, 253,
     28,  55, 153,  21, 120,
     91, 276, 231, 136,  78
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic iv0, iv1, iv2, or0, or1, or2;
  logic ir0, ir1, ir2, ov0, ov1, ov2, bz0, bz1, bz2;
  logic [1599:0] id0, id1, od0, od1;
  logic [199:0]  id2, od2;

  rho_serial #(.W(64), .LPC(5)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .busy(bz0));
  rho_serial #(.W(64), .LPC(25)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .busy(bz1));
  rho_serial #(.W(8), .LPC(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .busy(bz2));

  int checks = 0;
  int failures = 0;
  logic [1599:0] sb [$];

  typedef struct {
    int          lane;
    logic [63:0] val;
    int          dst;
    logic [63:0] exp;
  } vec_t;

  function automatic int n_of(input int k);
    return (k == 0) ? 5 : (k == 1) ? 1 : 25;
  endfunction

  function automatic int w_of(input int k);
    return (k == 2) ? 8 : 64;
  endfunction

  function automatic logic get_ov(input int k);
    return (k == 0) ? ov0 : (k == 1) ? ov1 : ov2;
  endfunction

  function automatic logic get_ir(input int k);
    return (k == 0) ? ir0 : (k == 1) ? ir1 : ir2;
  endfunction

  function automatic logic get_bz(input int k);
    return (k == 0) ? bz0 : (k == 1) ? bz1 : bz2;
  endfunction

  function automatic logic [1599:0] get_od(input int k);
    logic [1599:0] r;
    r = '0;
    if (k == 0) r = od0;
    else if (k == 1) r = od1;
    else r[199:0] = od2;
    return r;
  endfunction

  // out bit z of the rotated lane = in bit (z - r) mod w
  function automatic logic [1599:0] model(input logic [1599:0] d, input int w);
    logic [1599:0] o;
    int x, y, r, dst;
    o = '0;
    for (int l = 0; l < 25; l++) begin
      x = l / 5;
      y = l % 5;
      r = RHO_TAB[l] % w;
      dst = FUSE ? 5 * y + (2 * x + 3 * y) % 5 : l;
      for (int z = 0; z < w; z++) o[dst*w + z] = d[l*w + (z - r + w) % w];
    end
    return o;
  endfunction

  task automatic set_in(input int k, input logic v, input logic [1599:0] d);
    if (k == 0) begin iv0 = v; id0 = d; end
    else if (k == 1) begin iv1 = v; id1 = d; end
    else begin iv2 = v; id2 = d[199:0]; end
  endtask

  task automatic set_or(input int k, input logic v);
    if (k == 0) or0 = v;
    else if (k == 1) or1 = v;
    else or2 = v;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  task automatic chk_state(input string nm, input logic [1599:0] act,
                           input logic [1599:0] req, input int w);
    int bad;
    logic [63:0] m, la, lr, ba, br;
    bad = -1;
    ba = '0;
    br = '0;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    for (int l = 0; l < 25; l++) begin
      la = 64'(act >> (l * w)) & m;
      lr = 64'(req >> (l * w)) & m;
      if (la !== lr && bad < 0) begin
        bad = l;
        ba = la;
        br = lr;
      end
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s lane=%0d act=%0h req=%0h", nm, bad, ba, br);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout", nm);
  endtask

  // Returns at the negedge following the accept edge.
  task automatic send(input int k, input logic [1599:0] d, input logic [1599:0] e,
                      input bit push);
    int t;
    t = 0;
    while (!get_ir(k) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) timeout_fail("send_wait_ready");
    set_in(k, 1'b1, d);
    if (push) sb.push_back(e);
    @(negedge clk);
    set_in(k, 1'b0, d);
  endtask

  task automatic recv(input int k, input string nm);
    int cyc, bc;
    logic [1599:0] e;
    cyc = 0;
    bc = 0;
    while (!get_ov(k) && cyc < 100) begin
      if (get_bz(k)) bc++;
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_latency"}, 64'(cyc), 64'(n_of(k)));
    chk({nm, "_busy_cycles"}, 64'(bc), 64'(n_of(k)));
    if (sb.size() == 0) begin
      timeout_fail({nm, "_scoreboard_empty"});
    end else begin
      e = sb.pop_front();
      chk_state({nm, "_data"}, get_od(k), e, w_of(k));
    end
    set_or(k, 1'b1);
    @(negedge clk);
    set_or(k, 1'b0);
    chk({nm, "_out_valid_drop"}, 64'(get_ov(k)), 64'd0);
    chk({nm, "_in_ready_back"}, 64'(get_ir(k)), 64'd1);
  endtask

  function automatic logic [1599:0] rand_state(input int w);
    logic [1599:0] d;
    for (int i = 0; i < 50; i++) d[i*32 +: 32] = $urandom();
    for (int b = 25 * w; b < 1600; b++) d[b] = 1'b0;
    return d;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [7];
    logic [1599:0] d, e, snap, eb, b_st;
    int seen;
    bit stable;

    tbl[0] = '{lane: 5,  val: 64'h1,                   dst: FUSE ? 2 : 5,
               exp: 64'h2};
    tbl[1] = '{lane: 6,  val: 64'h1,                   dst: FUSE ? 5 : 6,
               exp: 64'h0000_1000_0000_0000};
    tbl[2] = '{lane: 0,  val: 64'hDEAD_BEEF_0123_4567, dst: 0,
               exp: 64'hDEAD_BEEF_0123_4567};
    tbl[3] = '{lane: 10, val: 64'h1,                   dst: FUSE ? 4 : 10,
               exp: 64'h4000_0000_0000_0000};
    tbl[4] = '{lane: 24, val: 64'h8000_0000_0000_0000, dst: FUSE ? 20 : 24,
               exp: 64'h0000_0000_0000_2000};
    tbl[5] = '{lane: 1,  val: 64'h0000_0000_1000_0000, dst: FUSE ? 8 : 1,
               exp: 64'h1};
    tbl[6] = '{lane: 18, val: 64'h8000_0000_0000_0001, dst: FUSE ? 15 : 18,
               exp: 64'h0000_0000_0030_0000};

    rst = 1'b1;
    iv0 = 0; iv1 = 0; iv2 = 0; or0 = 0; or1 = 0; or2 = 0;
    id0 = '0; id1 = '0; id2 = '0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", 64'(ir0), 64'd1);
    chk("reset_out_valid", 64'(ov0), 64'd0);
    chk("reset_busy", 64'(bz0), 64'd0);
    chk_state("reset_out_data", od0, '0, 64);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 64'(ir0), 64'd1);

    // single-lane vectors on the W=64/LPC=5 instance
    for (int i = 0; i < 7; i++) begin
      d = '0;
      d[tbl[i].lane*64 +: 64] = tbl[i].val;
      e = '0;
      e[tbl[i].dst*64 +: 64] = tbl[i].exp;
      send(0, d, e, 1'b1);
      recv(0, $sformatf("tbl%0d", i));
    end

    // W=64, LPC=25: lane(1,1)=1 rotates by 300 mod 64 = 44
    d = '0;
    d[6*64 +: 64] = 64'h1;
    e = '0;
    e[(FUSE ? 5 : 6)*64 +: 64] = 64'h0000_1000_0000_0000;
    send(1, d, e, 1'b1);
    recv(1, "lpc25");

    // W=8, LPC=1: lanes (1,1) and (0,1) both rotate by 4
    d = '0;
    d[6*8 +: 8] = 8'h01;
    d[1*8 +: 8] = 8'h01;
    e = '0;
    e[(FUSE ? 5 : 6)*8 +: 8] = 8'h10;
    e[(FUSE ? 8 : 1)*8 +: 8] = 8'h10;
    send(2, d, e, 1'b1);
    recv(2, "w8_lpc1");

    // random full states on every configuration
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        d = rand_state(w_of(k));
        send(k, d, model(d, w_of(k)), 1'b1);
        recv(k, $sformatf("rand_k%0d_%0d", k, j));
      end
    end

    // backpressure: DONE held for 10 cycles while a second state is offered
    d = rand_state(64);
    b_st = rand_state(64);
    eb = model(b_st, 64);
    send(0, d, model(d, 64), 1'b1);
    seen = 0;
    while (!ov0 && seen < 100) begin
      @(negedge clk);
      seen++;
    end
    if (seen >= 100) timeout_fail("bp_wait_out_valid");
    snap = od0;
    set_in(0, 1'b1, b_st);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (od0 !== snap || ir0 !== 1'b0 || ov0 !== 1'b1 || bz0 !== 1'b0) stable = 1'b0;
    end
    chk("bp_hold_stable", 64'(stable), 64'd1);
    e = sb.pop_front();
    chk_state("bp_first_data", od0, e, 64);
    sb.push_back(eb);
    or0 = 1'b1;
    @(negedge clk);
    or0 = 1'b0;
    chk("bp_out_valid_drop", 64'(ov0), 64'd0);
    chk("bp_in_ready_rise", 64'(ir0), 64'd1);
    chk("bp_not_busy_yet", 64'(bz0), 64'd0);
    @(negedge clk);
    set_in(0, 1'b0, b_st);
    chk("bp_second_busy", 64'(bz0), 64'd1);
    recv(0, "bp_second");

    // reset during BUSY cycle 3 discards the state
    d = rand_state(64);
    send(0, d, '0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(ov0), 64'd0);
    chk("midrst_busy", 64'(bz0), 64'd0);
    chk("midrst_in_ready", 64'(ir0), 64'd1);
    chk_state("midrst_out_data", od0, '0, 64);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ov0 || bz0) seen++;
    end
    chk("midrst_no_output", 64'(seen), 64'd0);
    d = rand_state(64);
    send(0, d, model(d, 64), 1'b1);
    recv(0, "after_rst");

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
